// File: rtl/md_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// No logic of its own.
// No flow control of its own.
package md_pkg;

  localparam int CNT_W = 5;

  // Operation encodings, shared with the main decoder
  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // MULT/MULTU/DIV/DIVU all have bit 2 clear; MT ops and reserved codes have it set
  function automatic logic is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit HI/LO result for MULT/MULTU/DIV/DIVU.
// Latency: zero cycles, purely combinational.
// Backpressure: none; result is captured by the sequencer when an op is accepted.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  i_md_op,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  input  hilo_t       i_hilo,
  output hilo_t       o_result
);

  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_b_zero;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_dvsr_s;
  logic [31:0] w_dvsr_u;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;

  assign w_a_neg  = i_src_a[31];
  assign w_b_neg  = i_src_b[31];
  assign w_b_zero = (i_src_b == 32'd0);

  // Magnitudes; 0x80000000 maps to itself, which is the correct unsigned magnitude
  assign w_a_mag = w_a_neg ? (32'd0 - i_src_a) : i_src_a;
  assign w_b_mag = w_b_neg ? (32'd0 - i_src_b) : i_src_b;

  assign w_prod_s = $signed({{32{i_src_a[31]}}, i_src_a}) * $signed({{32{i_src_b[31]}}, i_src_b});
  assign w_prod_u = {32'd0, i_src_a} * {32'd0, i_src_b};

  // Divisor forced non-zero so the divider never sees 0; the result is discarded in that case
  assign w_dvsr_s = w_b_zero ? 32'd1 : w_b_mag;
  assign w_dvsr_u = w_b_zero ? 32'd1 : i_src_b;

  assign w_q_mag = w_a_mag / w_dvsr_s;
  assign w_r_mag = w_a_mag % w_dvsr_s;
  assign w_q_u   = i_src_a / w_dvsr_u;
  assign w_r_u   = i_src_a % w_dvsr_u;

  // Quotient truncates toward zero; remainder follows the dividend's sign
  assign w_q_s = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r_s = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  // Select the result; divide by zero passes the current HI/LO through
  always_comb begin
    o_result = i_hilo;
    case (md_op_e'(i_md_op))
      MD_MULT:  o_result = w_prod_s;
      MD_MULTU: o_result = w_prod_u;
      MD_DIV:   if (!w_b_zero) o_result = {w_r_s, w_q_s};
      MD_DIVU:  if (!w_b_zero) o_result = {w_r_u, w_q_u};
      default:  o_result = i_hilo;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO for the EX stage.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles, HI/LO and done visible the cycle after.
// Backpressure: stall_D freezes decode while busy or while D needs HI/LO behind a starting op.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        use_md_D,
  output logic        busy,
  output logic        done,
  output logic        stall_D,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        r_state;
  md_state_e        w_next_state;
  logic [CNT_W-1:0] r_cnt;
  hilo_t            r_pend;
  hilo_t            r_hilo;
  logic             r_done;

  logic             w_arith_start;
  logic             w_busy;
  logic             w_accept;
  logic             w_commit;
  logic             w_mthi;
  logic             w_mtlo;
  logic [CNT_W-1:0] w_lat_ld;
  hilo_t            w_calc;

  md_calc u_calc (
    .i_md_op  (md_op),
    .i_src_a  (src_a),
    .i_src_b  (src_b),
    .i_hilo   (r_hilo),
    .o_result (w_calc)
  );

  assign w_arith_start = start & is_arith(md_op);
  assign w_lat_ld      = md_op[1] ? DIV_LD : MULT_LD;

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state: start an arithmetic op from idle, return once the counter expires
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_arith_start)  w_next_state = ST_BUSY;
      ST_BUSY: if (r_cnt == '0)    w_next_state = ST_IDLE;
      default:                     w_next_state = ST_IDLE;
    endcase
  end

  // State-derived controls; any start seen while busy is dropped here
  always_comb begin
    w_busy   = (r_state == ST_BUSY);
    w_accept = (r_state == ST_IDLE) & w_arith_start;
    w_commit = w_busy & (r_cnt == '0);
    w_mthi   = (r_state == ST_IDLE) & start & (md_op == MD_MTHI);
    w_mtlo   = (r_state == ST_IDLE) & start & (md_op == MD_MTLO);
  end

  // Counter, pending result, HI/LO and the commit pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_pend <= '0;
      r_hilo <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_accept) begin
        r_pend <= w_calc;
        r_cnt  <= w_lat_ld;
      end else if (w_busy && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_commit) begin
        r_hilo <= r_pend;
      end else begin
        if (w_mthi) r_hilo.hi <= src_a;
        if (w_mtlo) r_hilo.lo <= src_a;
      end
    end
  end

  assign busy    = w_busy;
  assign done    = r_done;
  assign hi      = r_hilo.hi;
  assign lo      = r_hilo.lo;
  assign stall_D = use_md_D & (w_busy | w_arith_start);

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer with a HI/LO scoreboard.
// Latency checked against MULT_CYCLES=5 / DIV_CYCLES=10.
// Exercises stall_D, ignored starts and asynchronous reset.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        use_md_D = 1'b0;
  logic        busy;
  logic        done;
  logic        stall_D;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .use_md_D (use_md_D),
    .busy     (busy),
    .done     (done),
    .stall_D  (stall_D),
    .hi       (hi),
    .lo       (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        scb[$];
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference model using 64-bit integer arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sbv, q, r;
    longint unsigned ua, ub;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      3'd0: return sa * sbv;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {m_hi, m_lo};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {m_hi, m_lo};
        return {a % b, a / b};
      end
      default: return {m_hi, m_lo};
    endcase
  endfunction

  // Drive a start for the current cycle; if tracked, update the model/scoreboard
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit track);
    exp_t        e;
    logic [63:0] r;
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    if (track) begin
      if (op <= 3'd3) begin
        r     = model(op, a, b);
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.lat = op[1] ? 10 : 5;
        scb.push_back(e);
        m_hi  = e.hi;
        m_lo  = e.lo;
      end else if (op == 3'd4) begin
        m_hi = a;
      end else if (op == 3'd5) begin
        m_lo = a;
      end
    end
  endtask

  task automatic fire(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b, 1'b1);
    step();
    start = 1'b0;
  endtask

  // Bounded wait for done, counting busy cycles on the way
  task automatic wait_done(output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    cmp_cnt++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b need all zero", hi, lo, busy, done);
    end
    fire(3'd4, 32'hCAFE0001, 32'd0);
    fire(3'd5, 32'hCAFE0002, 32'd0);
    // Mid-cycle reset: outputs must clear without a clock edge
    rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      err_cnt++;
      $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b need all zero", hi, lo, busy, done);
    end
    m_hi = 32'd0;
    m_lo = 32'd0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_mult();
    logic [2:0]  ops[4] = '{3'd0, 3'd1, 3'd0, 3'd1};
    logic [31:0] as[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h12345678};
    logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'h7FFFFFFF, 32'h9ABCDEF0};
    int   nb;
    bit   seen;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      fire(ops[k], as[k], bs[k]);
      wait_done(nb, seen);
      e = scb.pop_front();
      cmp_cnt++;
      if (!seen || nb != e.lat) begin
        err_cnt++;
        $display("FAIL mult_latency[%0d]: busy_cycles=%0d done_seen=%0d need %0d", k, nb, seen, e.lat);
      end
      cmp_cnt++;
      if (hi !== e.hi || lo !== e.lo) begin
        err_cnt++;
        $display("FAIL mult_result[%0d]: hi=%h lo=%h need hi=%h lo=%h", k, hi, lo, e.hi, e.lo);
      end
      step();
      cmp_cnt++;
      if (done !== 1'b0) begin
        err_cnt++;
        $display("FAIL mult_done_pulse[%0d]: done=%b need 0", k, done);
      end
    end
    // Spec constants for the first two operand sets
    cmp_cnt++;
    if (model(3'd0, 32'hFFFFFFFF, 32'd2) !== 64'hFFFFFFFF_FFFFFFFE ||
        model(3'd1, 32'hFFFFFFFF, 32'd2) !== 64'h00000001_FFFFFFFE) begin
      err_cnt++;
      $display("FAIL mult_model: model disagrees with known products");
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops[5] = '{3'd3, 3'd2, 3'd2, 3'd3, 3'd2};
    logic [31:0] as[5]  = '{32'd7, 32'hFFFFFFF9, 32'h80000000, 32'hF0000000, 32'd100};
    logic [31:0] bs[5]  = '{32'd0, 32'd2, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9};
    logic [31:0] ehi[3] = '{32'h11, 32'hFFFFFFFF, 32'h0};
    logic [31:0] elo[3] = '{32'h22, 32'hFFFFFFFD, 32'h80000000};
    int   nb;
    bit   seen;
    exp_t e;
    fire(3'd4, 32'h11, 32'd0);
    fire(3'd5, 32'h22, 32'd0);
    for (int k = 0; k < 5; k++) begin
      fire(ops[k], as[k], bs[k]);
      wait_done(nb, seen);
      e = scb.pop_front();
      if (k < 3) begin
        e.hi = ehi[k];
        e.lo = elo[k];
      end
      cmp_cnt++;
      if (!seen || nb != 10) begin
        err_cnt++;
        $display("FAIL div_latency[%0d]: busy_cycles=%0d done_seen=%0d need 10", k, nb, seen);
      end
      cmp_cnt++;
      if (hi !== e.hi || lo !== e.lo) begin
        err_cnt++;
        $display("FAIL div_result[%0d]: hi=%h lo=%h need hi=%h lo=%h", k, hi, lo, e.hi, e.lo);
      end
      m_hi = hi === e.hi ? m_hi : e.hi;
      m_lo = lo === e.lo ? m_lo : e.lo;
      step();
    end
  endtask

  task automatic test_stall();
    int   bad = 0;
    exp_t e;
    use_md_D = 1'b1;
    issue(3'd2, 32'd100, 32'd7, 1'b1);
    #1;
    cmp_cnt++;
    if (stall_D !== 1'b1) begin
      err_cnt++;
      $display("FAIL stall_at_start: stall_D=%b need 1", stall_D);
    end
    step();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 3) issue(3'd0, 32'd9, 32'd9, 1'b0);
      #1;
      if (stall_D !== 1'b1 || busy !== 1'b1) bad++;
      step();
      start = 1'b0;
    end
    cmp_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL stall_during_busy: %0d bad cycles need 0", bad);
    end
    #1;
    e = scb.pop_front();
    cmp_cnt++;
    if (stall_D !== 1'b0 || done !== 1'b1 || hi !== e.hi || lo !== e.lo) begin
      err_cnt++;
      $display("FAIL stall_release: stall_D=%b done=%b hi=%h lo=%h need 0 1 %h %h", stall_D, done, hi, lo, e.hi, e.lo);
    end
    step();
    cmp_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || scb.size() != 0) begin
      err_cnt++;
      $display("FAIL ignored_start: busy=%b done=%b queued=%0d need 0 0 0", busy, done, scb.size());
    end
    issue(3'd4, 32'h0BADF00D, 32'd0, 1'b1);
    #1;
    cmp_cnt++;
    if (stall_D !== 1'b0) begin
      err_cnt++;
      $display("FAIL stall_mt: stall_D=%b need 0", stall_D);
    end
    step();
    start = 1'b0;
    use_md_D = 1'b0;
  endtask

  task automatic test_mt();
    logic [31:0] lo_before;
    int          nb;
    bit          seen;
    exp_t        e;
    fire(3'd4, 32'hDEADBEEF, 32'd0);
    cmp_cnt++;
    if (hi !== 32'hDEADBEEF || busy !== 1'b0 || done !== 1'b0) begin
      err_cnt++;
      $display("FAIL mthi: hi=%h busy=%b done=%b need deadbeef 0 0", hi, busy, done);
    end
    fire(3'd5, 32'h600DC0DE, 32'd0);
    cmp_cnt++;
    if (lo !== 32'h600DC0DE || hi !== 32'hDEADBEEF) begin
      err_cnt++;
      $display("FAIL mtlo: hi=%h lo=%h need deadbeef 600dc0de", hi, lo);
    end
    lo_before = lo;
    fire(3'd0, 32'd3, 32'd4);
    issue(3'd5, 32'h55555555, 32'd0, 1'b0);
    step();
    start = 1'b0;
    cmp_cnt++;
    if (lo !== lo_before) begin
      err_cnt++;
      $display("FAIL mtlo_busy: lo=%h need %h", lo, lo_before);
    end
    wait_done(nb, seen);
    e = scb.pop_front();
    cmp_cnt++;
    if (!seen || hi !== e.hi || lo !== e.lo) begin
      err_cnt++;
      $display("FAIL mt_then_mult: seen=%0d hi=%h lo=%h need %h %h", seen, hi, lo, e.hi, e.lo);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int   dones = 0;
    int   nb;
    bit   seen;
    exp_t e;
    fire(3'd4, 32'h00001234, 32'd0);
    fire(3'd0, 32'd5, 32'd6);
    step();
    step();
    rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_abort: busy=%b hi=%h lo=%h need 0 0 0", busy, hi, lo);
    end
    void'(scb.pop_back());
    m_hi = 32'd0;
    m_lo = 32'd0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) dones++;
      step();
    end
    cmp_cnt++;
    if (dones != 0) begin
      err_cnt++;
      $display("FAIL reset_no_commit: %0d cycles with activity need 0", dones);
    end
    fire(3'd0, 32'h10, 32'h20);
    wait_done(nb, seen);
    e = scb.pop_front();
    cmp_cnt++;
    if (!seen || nb != 5 || hi !== e.hi || lo !== e.lo) begin
      err_cnt++;
      $display("FAIL mult_after_reset: seen=%0d busy_cycles=%0d hi=%h lo=%h need 1 5 %h %h", seen, nb, hi, lo, e.hi, e.lo);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_mt();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
